// File: rtl/c5efa7_bts_led_pkg.sv
// Shared definitions for the LED fader: per-channel fade state encoding and
// pin polarity helpers used by the channel output flop.
package c5efa7_bts_led_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_t;

    localparam logic LIT  = 1'b1;
    localparam logic DARK = 1'b0;

    // Converts a logical lit/dark value into the physical pin level.
    function automatic logic led_drive(input logic lit, input logic active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/c5efa7_bts_led_fade_channel.sv
// One LED channel: fade FSM with brightness level, PWM compare and the
// registered pin drive.
module c5efa7_bts_led_fade_channel
    import c5efa7_bts_led_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                led_q,
    input  logic                step_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};

    fade_state_t         state;
    fade_state_t         state_next;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic                lit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_OFF;
            level   <= '0;
            led_out <= led_drive(DARK, LED_ACTIVE_LOW);
        end else begin
            state   <= state_next;
            level   <= level_next;
            led_out <= led_drive(lit, LED_ACTIVE_LOW);
        end
    end

    // A direction change takes priority over a coincident step; the end
    // guards keep level from ever wrapping, even for a very short request.
    always_comb begin
        state_next = state;
        level_next = level;
        case (state)
            ST_OFF: begin
                if (led_q) state_next = ST_UP;
            end
            ST_UP: begin
                if (!led_q) begin
                    state_next = ST_DOWN;
                end else if (level == LEVEL_MAX) begin
                    state_next = ST_ON;
                end else if (step_tick) begin
                    level_next = level + 1'b1;
                    if (level == LEVEL_MAX - 1'b1) state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (!led_q) state_next = ST_DOWN;
            end
            ST_DOWN: begin
                if (led_q) begin
                    state_next = ST_UP;
                end else if (level == '0) begin
                    state_next = ST_OFF;
                end else if (step_tick) begin
                    level_next = level - 1'b1;
                    if (level == {{(PWM_BITS-1){1'b0}}, 1'b1}) state_next = ST_OFF;
                end
            end
            default: begin
                state_next = ST_OFF;
                level_next = '0;
            end
        endcase
    end

    // Full brightness is forced lit so there is no dark cycle at pwm_cnt wrap.
    assign lit     = (level == LEVEL_MAX) || (level > pwm_cnt);
    assign ramping = (state == ST_UP) || (state == ST_DOWN);

endmodule

// File: rtl/c5efa7_bts_led_fader.sv
// LED fader top: registers the PIO request bits, shares one step prescaler and
// one PWM counter across all channels, and reports whether any channel ramps.
module c5efa7_bts_led_fader
    import c5efa7_bts_led_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int PWM_BITS       = 8,
    parameter int STEP_DIV       = 4096,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [NUM_LEDS-1:0] led_q;
    logic [PRESC_W-1:0]  prescaler;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] ramping;

    assign step_tick = (prescaler == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            led_q     <= led_in;
            prescaler <= step_tick ? '0 : prescaler + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            busy      <= |ramping;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        c5efa7_bts_led_fade_channel #(
            .PWM_BITS       (PWM_BITS),
            .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .led_q     (led_q[i]),
            .step_tick (step_tick),
            .pwm_cnt   (pwm_cnt),
            .led_out   (led_out[i]),
            .ramping   (ramping[i])
        );
    end

endmodule
